tilelink_1ton_uh: RTL

- TileLink-UH 1-to-N crossbar leaf: one master A/D port fanned out to NS slave ports.
- Routes each A request by address decode, including whole multi-beat Put bursts, to the matching slave.
- Arbitrates slave D responses back to the single master.
- Unmapped addresses are answered locally by an internal denied-error responder.
- Sits downstream of the M-to-1 arbiter, in front of peripheral and memory slaves.

---
 rtl/tilelink_1ton_uh.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tilelink_1ton_uh.sv
// TileLink-UH 1-to-N leaf: registered A-path address decode with Put-burst locking,
// an internal denied-error responder, and round-robin D-path arbitration back to the master.
module tilelink_1ton_uh #(
  parameter int C_NUM_SLAVES          = 2,
  parameter int C_TILELINK_DATA_WIDTH = 32,
  parameter int C_TILELINK_ADDR_WIDTH = 32,
  parameter int C_TILELINK_ID_WIDTH   = 5,
  parameter logic [C_NUM_SLAVES*C_TILELINK_ADDR_WIDTH-1:0] C_SLAVE_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [C_NUM_SLAVES*C_TILELINK_ADDR_WIDTH-1:0] C_SLAVE_MASK = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                                            tilelink_clock_i,
  input  logic                                            tilelink_reset_ni,
  input  logic [2:0]                                      master_a_opcode,
  input  logic [2:0]                                      master_a_param,
  input  logic [2:0]                                      master_a_size,
  input  logic [C_TILELINK_ID_WIDTH-1:0]                  master_a_source,
  input  logic [C_TILELINK_ADDR_WIDTH-1:0]                master_a_address,
  input  logic [C_TILELINK_DATA_WIDTH/8-1:0]              master_a_mask,
  input  logic [C_TILELINK_DATA_WIDTH-1:0]                master_a_data,
  input  logic                                            master_a_corrupt,
  input  logic                                            master_a_valid,
  output logic                                            master_a_ready,
  output logic [2:0]                                      master_d_opcode,
  output logic [1:0]                                      master_d_param,
  output logic [2:0]                                      master_d_size,
  output logic [C_TILELINK_ID_WIDTH-1:0]                  master_d_source,
  output logic                                            master_d_denied,
  output logic                                            master_d_corrupt,
  output logic                                            master_d_valid,
  output logic [C_TILELINK_DATA_WIDTH-1:0]                master_d_data,
  input  logic                                            master_d_ready,
  output logic [C_NUM_SLAVES*3-1:0]                       slave_a_opcode,
  output logic [C_NUM_SLAVES*3-1:0]                       slave_a_param,
  output logic [C_NUM_SLAVES*3-1:0]                       slave_a_size,
  output logic [C_NUM_SLAVES*C_TILELINK_ID_WIDTH-1:0]     slave_a_source,
  output logic [C_NUM_SLAVES*C_TILELINK_ADDR_WIDTH-1:0]   slave_a_address,
  output logic [C_NUM_SLAVES*C_TILELINK_DATA_WIDTH/8-1:0] slave_a_mask,
  output logic [C_NUM_SLAVES*C_TILELINK_DATA_WIDTH-1:0]   slave_a_data,
  output logic [C_NUM_SLAVES-1:0]                         slave_a_corrupt,
  output logic [C_NUM_SLAVES-1:0]                         slave_a_valid,
  input  logic [C_NUM_SLAVES-1:0]                         slave_a_ready,
  input  logic [C_NUM_SLAVES*3-1:0]                       slave_d_opcode,
  input  logic [C_NUM_SLAVES*2-1:0]                       slave_d_param,
  input  logic [C_NUM_SLAVES*3-1:0]                       slave_d_size,
  input  logic [C_NUM_SLAVES*C_TILELINK_ID_WIDTH-1:0]     slave_d_source,
  input  logic [C_NUM_SLAVES-1:0]                         slave_d_denied,
  input  logic [C_NUM_SLAVES*C_TILELINK_DATA_WIDTH-1:0]   slave_d_data,
  input  logic [C_NUM_SLAVES-1:0]                         slave_d_corrupt,
  input  logic [C_NUM_SLAVES-1:0]                         slave_d_valid,
  output logic [C_NUM_SLAVES-1:0]                         slave_d_ready
);
  localparam int NS  = C_NUM_SLAVES;
  localparam int DW  = C_TILELINK_DATA_WIDTH;
  localparam int AW  = C_TILELINK_ADDR_WIDTH;
  localparam int IDW = C_TILELINK_ID_WIDTH;
  localparam int MW  = DW / 8;
  localparam int LGB = $clog2(MW);
  localparam int TW  = $clog2(NS + 1);
  localparam logic [TW-1:0] ERR_IDX = TW'(NS);
  localparam logic [1:0] ERR_IDLE = 2'd0, ERR_PUT = 2'd1, ERR_RESP = 2'd2;

  // Beats in a burst of 2^size bytes; anything up to one bus width is a single beat.
  function automatic logic [7:0] beats_of(input logic [2:0] size);
    logic [2:0] sh;
    sh = size - 3'(LGB);
    if (size <= 3'(LGB)) beats_of = 8'd1;
    else                 beats_of = 8'd1 << sh;
  endfunction

  function automatic logic [TW-1:0] next_idx(input logic [TW-1:0] idx);
    next_idx = (idx == ERR_IDX) ? '0 : idx + 1'b1;
  endfunction

  // ---------------- A path ----------------
  logic            a_valid_q;
  logic [TW-1:0]   tgt_q, a_lock_tgt_q, dec_tgt, a_tgt;
  logic [7:0]      a_cnt_q;
  logic [2:0]      a_opcode_q, a_param_q, a_size_q;
  logic [IDW-1:0]  a_source_q;
  logic [AW-1:0]   a_address_q;
  logic [MW-1:0]   a_mask_q;
  logic [DW-1:0]   a_data_q;
  logic            a_corrupt_q;
  logic [NS:0]     tgt_ready_vec;
  logic            tgt_ready, a_accept, a_multi_put, err_a_ready;

  // Iterating downwards leaves the lowest-index hit as the winner.
  always_comb begin
    dec_tgt = ERR_IDX;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((master_a_address & C_SLAVE_MASK[i*AW +: AW]) == C_SLAVE_BASE[i*AW +: AW])
        dec_tgt = TW'(i);
    end
  end

  assign a_tgt          = (a_cnt_q != 8'd0) ? a_lock_tgt_q : dec_tgt;
  assign tgt_ready_vec  = {err_a_ready, slave_a_ready};
  assign tgt_ready      = tgt_ready_vec[tgt_q];
  assign master_a_ready = !a_valid_q | tgt_ready;
  assign a_accept       = master_a_valid & master_a_ready;
  assign a_multi_put    = (master_a_opcode == 3'd0 || master_a_opcode == 3'd1) && (master_a_size > 3'(LGB));

  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
    if (!tilelink_reset_ni) begin
      a_valid_q    <= 1'b0;
      tgt_q        <= '0;
      a_cnt_q      <= 8'd0;
      a_lock_tgt_q <= '0;
    end else begin
      if (master_a_ready) a_valid_q <= master_a_valid;
      if (a_accept) begin
        tgt_q <= a_tgt;
        if (a_cnt_q != 8'd0) begin
          a_cnt_q <= a_cnt_q - 8'd1;
        end else if (a_multi_put) begin
          a_cnt_q      <= beats_of(master_a_size) - 8'd1;
          a_lock_tgt_q <= dec_tgt;
        end
      end
    end
  end

  always_ff @(posedge tilelink_clock_i) begin
    if (a_accept) begin
      a_opcode_q  <= master_a_opcode;
      a_param_q   <= master_a_param;
      a_size_q    <= master_a_size;
      a_source_q  <= master_a_source;
      a_address_q <= master_a_address;
      a_mask_q    <= master_a_mask;
      a_data_q    <= master_a_data;
      a_corrupt_q <= master_a_corrupt;
    end
  end

  // ---------------- Error responder ----------------
  logic [1:0]     err_state_q;
  logic [7:0]     err_cnt_q;
  logic           err_op_q;
  logic [2:0]     err_size_q;
  logic [IDW-1:0] err_source_q;
  logic           err_accept, err_d_ready, err_put;

  // Put bursts keep flowing into the responder; only the D phase blocks new A beats.
  assign err_a_ready = (err_state_q != ERR_RESP);
  assign err_accept  = a_valid_q & (tgt_q == ERR_IDX) & err_a_ready;
  assign err_put     = (a_opcode_q == 3'd0) || (a_opcode_q == 3'd1);

  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
    if (!tilelink_reset_ni) begin
      err_state_q  <= ERR_IDLE;
      err_cnt_q    <= 8'd0;
      err_op_q     <= 1'b0;
      err_size_q   <= 3'd0;
      err_source_q <= '0;
    end else begin
      case (err_state_q)
        ERR_IDLE: if (err_accept) begin
          err_size_q   <= a_size_q;
          err_source_q <= a_source_q;
          err_op_q     <= !err_put;
          if (err_put && beats_of(a_size_q) > 8'd1) begin
            err_cnt_q   <= beats_of(a_size_q) - 8'd1;
            err_state_q <= ERR_PUT;
          end else begin
            err_cnt_q   <= err_put ? 8'd1 : beats_of(a_size_q);
            err_state_q <= ERR_RESP;
          end
        end
        ERR_PUT: if (err_accept) begin
          if (err_cnt_q == 8'd1) err_state_q <= ERR_RESP;
          else                   err_cnt_q   <= err_cnt_q - 8'd1;
        end
        ERR_RESP: if (err_d_ready) begin
          if (err_cnt_q == 8'd1) err_state_q <= ERR_IDLE;
          err_cnt_q <= err_cnt_q - 8'd1;
        end
        default: err_state_q <= ERR_IDLE;
      endcase
    end
  end

  // ---------------- D path ----------------
  logic [NS:0]    src_valid;
  logic [2:0]     src_opcode [NS+1];
  logic [1:0]     src_param  [NS+1];
  logic [2:0]     src_size   [NS+1];
  logic [IDW-1:0] src_source [NS+1];
  logic           src_denied [NS+1];
  logic           src_corrupt[NS+1];
  logic [DW-1:0]  src_data   [NS+1];
  logic [TW-1:0]  rr_q, grant_idx, d_lock_idx_q;
  logic           grant_any, d_load, d_fire, d_lock_q, d_multi;
  logic [7:0]     d_cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slave
      assign slave_a_valid[gi]             = a_valid_q & (tgt_q == TW'(gi));
      assign slave_a_opcode[gi*3 +: 3]     = a_opcode_q;
      assign slave_a_param[gi*3 +: 3]      = a_param_q;
      assign slave_a_size[gi*3 +: 3]       = a_size_q;
      assign slave_a_source[gi*IDW +: IDW] = a_source_q;
      assign slave_a_address[gi*AW +: AW]  = a_address_q;
      assign slave_a_mask[gi*MW +: MW]     = a_mask_q;
      assign slave_a_data[gi*DW +: DW]     = a_data_q;
      assign slave_a_corrupt[gi]           = a_corrupt_q;
      assign src_valid[gi]   = slave_d_valid[gi];
      assign src_opcode[gi]  = slave_d_opcode[gi*3 +: 3];
      assign src_param[gi]   = slave_d_param[gi*2 +: 2];
      assign src_size[gi]    = slave_d_size[gi*3 +: 3];
      assign src_source[gi]  = slave_d_source[gi*IDW +: IDW];
      assign src_denied[gi]  = slave_d_denied[gi];
      assign src_corrupt[gi] = slave_d_corrupt[gi];
      assign src_data[gi]    = slave_d_data[gi*DW +: DW];
      assign slave_d_ready[gi] = grant_any & d_load & (grant_idx == TW'(gi));
    end
  endgenerate

  assign src_valid[NS]   = (err_state_q == ERR_RESP);
  assign src_opcode[NS]  = err_op_q ? 3'd1 : 3'd0;
  assign src_param[NS]   = 2'd0;
  assign src_size[NS]    = err_size_q;
  assign src_source[NS]  = err_source_q;
  assign src_denied[NS]  = 1'b1;
  assign src_corrupt[NS] = err_op_q;
  assign src_data[NS]    = '0;
  assign err_d_ready     = grant_any & d_load & (grant_idx == ERR_IDX);

  // Scan from rr_q upward with wrap; the scan runs backwards so the nearest valid source wins.
  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = rr_q;
    if (d_lock_q) begin
      grant_any = 1'b1;
      grant_idx = d_lock_idx_q;
    end else begin
      for (int k = NS; k >= 0; k--) begin
        j = int'(rr_q) + k;
        if (j > NS) j = j - (NS + 1);
        if (src_valid[j]) begin
          grant_any = 1'b1;
          grant_idx = TW'(j);
        end
      end
    end
  end

  assign d_load  = !master_d_valid | master_d_ready;
  assign d_fire  = grant_any & src_valid[grant_idx] & d_load;
  assign d_multi = (src_opcode[grant_idx] == 3'd1) && (src_size[grant_idx] > 3'(LGB));

  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
    if (!tilelink_reset_ni) begin
      master_d_valid <= 1'b0;
      rr_q           <= '0;
      d_lock_q       <= 1'b0;
      d_lock_idx_q   <= '0;
      d_cnt_q        <= 8'd0;
    end else if (d_fire) begin
      master_d_valid <= 1'b1;
      if (d_lock_q) begin
        d_cnt_q <= d_cnt_q - 8'd1;
        if (d_cnt_q == 8'd1) begin
          d_lock_q <= 1'b0;
          rr_q     <= next_idx(grant_idx);
        end
      end else if (d_multi) begin
        d_lock_q     <= 1'b1;
        d_lock_idx_q <= grant_idx;
        d_cnt_q      <= beats_of(src_size[grant_idx]) - 8'd1;
      end else begin
        rr_q <= next_idx(grant_idx);
      end
    end else if (master_d_ready) begin
      master_d_valid <= 1'b0;
    end
  end

  always_ff @(posedge tilelink_clock_i) begin
    if (d_fire) begin
      master_d_opcode  <= src_opcode[grant_idx];
      master_d_param   <= src_param[grant_idx];
      master_d_size    <= src_size[grant_idx];
      master_d_source  <= src_source[grant_idx];
      master_d_denied  <= src_denied[grant_idx];
      master_d_corrupt <= src_corrupt[grant_idx];
      master_d_data    <= src_data[grant_idx];
    end
  end
endmodule
